mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width of the upstream multiplier; product is 2*WIDTH bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: accumulator width; ACC_WIDTH >= 2*WIDTH is required.
REQ-003 SHALL have parameter NTERMS, default 8: number of products summed per result; NTERMS >= 1 is required.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 prod_valid  input  1  product word present.
REQ-008 prod_h  input  WIDTH  product high half, two's complement, from the multiplier.
REQ-009 prod_l  input  WIDTH  product low half, from the multiplier.
REQ-010 prod_ready  output  1  block accepts a product this cycle.
REQ-011 clear  input  1  abort the current sum and restart it.
REQ-012 acc_out_valid  output  1  result available.
REQ-013 acc_out_ready  input  1  consumer takes the result.
REQ-014 acc_out  output  ACC_WIDTH  signed accumulated result.
REQ-015 acc_ovf  output  1  saturation occurred in the current or presented sum.
REQ-016 term_cnt  output  clog2(NTERMS+1)  products accepted in the current sum.

Function
REQ-017 SHALL form the product as signed {prod_h, prod_l} and sign-extend it to ACC_WIDTH.
REQ-018 SHALL implement two states: ACCUM and OUTPUT.
REQ-019 In ACCUM: prod_ready = !clear and acc_out_valid = 0. In OUTPUT: prod_ready = 0 and acc_out_valid = 1.
REQ-020 A product SHALL be accepted on any rising edge where prod_valid && prod_ready.
  - On acceptance: acc <= sat(acc + ext(product)); term_cnt increments.
REQ-021 Saturation SHALL clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) and SHALL set acc_ovf sticky until the sum is restarted.
REQ-022 On the edge that accepts the NTERMS-th product, SHALL go to OUTPUT.
  - acc_out_valid SHALL be high in the following cycle.
  - Latency from last accept to valid: 1 cycle.
REQ-023 In OUTPUT, acc_out, acc_ovf and term_cnt (= NTERMS) SHALL hold stable until acc_out_valid && acc_out_ready.
REQ-024 On the OUTPUT handshake edge: acc <= 0, term_cnt <= 0, acc_ovf <= 0, state <= ACCUM.
  - A product SHALL be acceptable in the very next cycle.
REQ-025 clear in ACCUM: acc, term_cnt and acc_ovf SHALL go to 0 on that edge.
  - A simultaneous prod_valid SHALL NOT be accepted, because prod_ready = 0 while clear is high.
REQ-026 clear in OUTPUT SHALL be ignored.
REQ-027 acc_out SHALL continuously reflect the accumulator register, in both states.
REQ-028 With NTERMS = 1, each accepted product SHALL produce one result.
REQ-029 Products presented without prod_ready SHALL NOT change any state; upstream holds them.

Reset
REQ-030 While rst is high at a rising edge, on that edge: state <= ACCUM, acc <= 0, term_cnt <= 0, acc_ovf <= 0.
  - Resulting outputs: acc_out_valid = 0, prod_ready = 1 (clear low).
REQ-031 rst SHALL take priority over clear, accepts and handshakes in the same cycle.
  - Reset mid-sum or in OUTPUT SHALL discard the partial result or the pending result.

Verification
REQ-032 NTERMS=4, ACC_WIDTH=40: products 3, -5, 100, 2 back-to-back -> acc_out_valid one cycle after 4th accept, acc_out=100, acc_ovf=0, term_cnt=4.
REQ-033 ACC_WIDTH=32, NTERMS=4: four products 0x40000000 -> acc_out=0x7FFFFFFF, acc_ovf=1; four products 0xC0000000 -> acc_out=0x80000000, acc_ovf=1.
REQ-034 acc_out_ready low for 5 cycles with a result pending -> prod_ready=0, acc_out stable throughout; ready high -> next cycle acc_out=0, term_cnt=0, prod_ready=1.
REQ-035 After 2 accepts (10, 20), assert clear with prod_valid high -> product not accepted, acc_out=0, term_cnt=0; next 4 products 1,1,1,1 -> acc_out=4.
REQ-036 rst pulsed after 3 accepts, and separately during OUTPUT -> acc_out=0, acc_out_valid=0, term_cnt=0, acc_ovf=0 on the following cycle.

Source files
------------

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating multiply-accumulate over NTERMS products
//
// Sums NTERMS signed products {prod_h, prod_l} into a saturating ACC_WIDTH
// accumulator, then presents the sum until the consumer takes it.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   prod_valid    product word present
//   prod_h        product high half (two's complement)
//   prod_l        product low half
//   prod_ready    product accepted this cycle when prod_valid is high
//   clear         abort the current sum and restart it (ignored while presenting)
//   acc_out_valid result available
//   acc_out_ready consumer takes the result
//   acc_out       signed accumulator value (always reflects the register)
//   acc_ovf       saturation occurred in the current or presented sum
//   term_cnt      products accepted in the current sum
module mac_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int NTERMS    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             prod_valid,
  input  logic [WIDTH-1:0]                 prod_h,
  input  logic [WIDTH-1:0]                 prod_l,
  output logic                             prod_ready,
  input  logic                             clear,
  output logic                             acc_out_valid,
  input  logic                             acc_out_ready,
  output logic [ACC_WIDTH-1:0]             acc_out,
  output logic                             acc_ovf,
  output logic [$clog2(NTERMS+1)-1:0]      term_cnt
);

  localparam int CNT_W = $clog2(NTERMS + 1);
  localparam int EXT_W = ACC_WIDTH + 1 - 2 * WIDTH;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [2*WIDTH-1:0]     prod;
  logic [ACC_WIDTH:0]     sum;
  logic                   pos_ovf;
  logic                   neg_ovf;
  logic [ACC_WIDTH-1:0]   sat_sum;
  logic                   last_term;

  assign prod = {prod_h, prod_l};

  // One guard bit above the accumulator: the sum of an ACC_WIDTH value and a
  // narrower sign-extended product cannot overflow ACC_WIDTH+1 bits, so a
  // disagreement between the top two bits flags saturation and its direction.
  assign sum     = {acc_q[ACC_WIDTH-1], acc_q} + {{EXT_W{prod[2*WIDTH-1]}}, prod};
  assign pos_ovf = !sum[ACC_WIDTH] &&  sum[ACC_WIDTH-1];
  assign neg_ovf =  sum[ACC_WIDTH] && !sum[ACC_WIDTH-1];

  always_comb begin
    sat_sum = sum[ACC_WIDTH-1:0];
    if (pos_ovf) begin
      sat_sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else if (neg_ovf) begin
      sat_sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end
  end

  assign last_term = (cnt_q == CNT_W'(NTERMS - 1));

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    prod_ready    = 1'b0;
    acc_out_valid = 1'b0;

    if (state_q == ACCUM) begin
      // clear blocks acceptance so a product on the clear cycle is held upstream
      prod_ready = !clear;
      if (clear) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (prod_valid) begin
        acc_d = sat_sum;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q || pos_ovf || neg_ovf;
        if (last_term) begin
          state_d = OUTPUT;
        end
      end
    end else begin
      acc_out_valid = 1'b1;
      if (acc_out_ready) begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign acc_ovf  = ovf_q;
  assign term_cnt = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [15:0] prod_h = '0;
  logic [15:0] prod_l = '0;
  logic        clear = 1'b0;
  logic        acc_out_ready = 1'b0;
  logic        c_valid = 1'b0;
  logic        c_ready = 1'b0;

  logic        ready_a, valid_a, ovf_a;
  logic [39:0] acc_a;
  logic [2:0]  term_a;
  logic        ready_b, valid_b, ovf_b;
  logic [31:0] acc_b;
  logic [2:0]  term_b;
  logic        ready_c, valid_c, ovf_c;
  logic [39:0] acc_c;
  logic [0:0]  term_c;

  int checks = 0;
  int errors = 0;

  longint      ma, mb;
  bit          oa, ob;
  int          mcnt;
  logic [40:0] qa[$];
  logic [32:0] qb[$];

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .NTERMS(4)) dut_a (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_h(prod_h), .prod_l(prod_l),
    .prod_ready(ready_a), .clear(clear), .acc_out_valid(valid_a),
    .acc_out_ready(acc_out_ready), .acc_out(acc_a), .acc_ovf(ovf_a), .term_cnt(term_a)
  );

  mac_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .NTERMS(4)) dut_b (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_h(prod_h), .prod_l(prod_l),
    .prod_ready(ready_b), .clear(clear), .acc_out_valid(valid_b),
    .acc_out_ready(acc_out_ready), .acc_out(acc_b), .acc_ovf(ovf_b), .term_cnt(term_b)
  );

  mac_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .NTERMS(1)) dut_c (
    .clk(clk), .rst(rst), .prod_valid(c_valid), .prod_h(prod_h), .prod_l(prod_l),
    .prod_ready(ready_c), .clear(clear), .acc_out_valid(valid_c),
    .acc_out_ready(c_ready), .acc_out(acc_c), .acc_ovf(ovf_c), .term_cnt(term_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint s, input int w, output bit ov);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    ov = 1'b0;
    if (s > hi) begin
      ov = 1'b1;
      return hi;
    end
    if (s < lo) begin
      ov = 1'b1;
      return lo;
    end
    return s;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; oa = 0; ob = 0; mcnt = 0;
  endtask

  // Drives one product for one edge; the DUT must be ready for it.
  task automatic accept(input logic [31:0] p);
    bit     t;
    longint pv;
    prod_valid = 1'b1;
    {prod_h, prod_l} = p;
    #1;
    check("prod_ready_a", 64'(ready_a), 64'(1));
    pv = longint'($signed(p));
    ma = sat(ma + pv, 40, t); oa = oa | t;
    mb = sat(mb + pv, 32, t); ob = ob | t;
    mcnt++;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    if (mcnt == 4) begin
      qa.push_back({oa, ma[39:0]});
      qb.push_back({ob, mb[31:0]});
      model_reset();
    end
  endtask

  // Completes the output handshake and compares against the scoreboard.
  task automatic take();
    logic [40:0] ea;
    logic [32:0] eb;
    check("out_valid_a", 64'(valid_a), 64'(1));
    check("out_valid_b", 64'(valid_b), 64'(1));
    check("sb_pending", 64'(qa.size() > 0 && qb.size() > 0), 64'(1));
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("result_acc_a", 64'(acc_a), 64'(ea[39:0]));
      check("result_ovf_a", 64'(ovf_a), 64'(ea[40]));
      check("result_acc_b", 64'(acc_b), 64'(eb[31:0]));
      check("result_ovf_b", 64'(ovf_b), 64'(eb[32]));
      check("result_term_a", 64'(term_a), 64'(4));
    end
    acc_out_ready = 1'b1;
    @(posedge clk); #1;
    acc_out_ready = 1'b0;
    check("post_take_valid", 64'(valid_a), 64'(0));
    check("post_take_acc", 64'(acc_a), 64'(0));
    check("post_take_term", 64'(term_a), 64'(0));
    check("post_take_ready", 64'(ready_a), 64'(1));
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    qa.delete();
    qb.delete();
    check({tag, "_acc_a"}, 64'(acc_a), 64'(0));
    check({tag, "_valid_a"}, 64'(valid_a), 64'(0));
    check({tag, "_term_a"}, 64'(term_a), 64'(0));
    check({tag, "_ovf_b"}, 64'(ovf_b), 64'(0));
    check({tag, "_ready_a"}, 64'(ready_a), 64'(1));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 64'(ready_a), 64'(1));
    check("rst_valid", 64'(valid_a), 64'(0));
    check("rst_acc", 64'(acc_a), 64'(0));
    check("rst_term", 64'(term_a), 64'(0));
    check("rst_ovf", 64'(ovf_a), 64'(0));

    // Back-to-back products 3, -5, 100, 2
    accept(32'd3);
    accept(32'hFFFF_FFFB);
    check("mid_term", 64'(term_a), 64'(2));
    check("mid_acc", 64'(acc_a), 64'(40'hFF_FFFF_FFFE));
    accept(32'd100);
    accept(32'd2);
    check("sum_valid", 64'(valid_a), 64'(1));
    check("sum_acc", 64'(acc_a), 64'(100));
    check("sum_ovf", 64'(ovf_a), 64'(0));
    check("sum_term", 64'(term_a), 64'(4));

    // Stall: consumer not ready, product and clear offered meanwhile
    prod_valid = 1'b1;
    {prod_h, prod_l} = 32'd7;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      #1;
      check("stall_ready", 64'(ready_a), 64'(0));
      check("stall_acc", 64'(acc_a), 64'(100));
      check("stall_term", 64'(term_a), 64'(4));
      @(posedge clk); #1;
    end
    clear = 1'b0;
    prod_valid = 1'b0;
    take();

    // Saturation on the 32-bit accumulator, none on the 40-bit one
    repeat (4) accept(32'h4000_0000);
    check("satp_acc_b", 64'(acc_b), 64'(32'h7FFF_FFFF));
    check("satp_ovf_b", 64'(ovf_b), 64'(1));
    check("satp_acc_a", 64'(acc_a), 64'(40'h01_0000_0000));
    take();
    repeat (4) accept(32'hC000_0000);
    check("satn_acc_b", 64'(acc_b), 64'(32'h8000_0000));
    check("satn_ovf_b", 64'(ovf_b), 64'(1));
    check("satn_acc_a", 64'(acc_a), 64'(40'hFF_0000_0000));
    take();

    // clear with a simultaneous product
    accept(32'd10);
    accept(32'd20);
    prod_valid = 1'b1;
    {prod_h, prod_l} = 32'd55;
    clear = 1'b1;
    #1;
    check("clear_ready", 64'(ready_a), 64'(0));
    @(posedge clk); #1;
    clear = 1'b0;
    prod_valid = 1'b0;
    model_reset();
    check("clear_acc", 64'(acc_a), 64'(0));
    check("clear_term", 64'(term_a), 64'(0));
    repeat (4) accept(32'd1);
    check("after_clear_acc", 64'(acc_a), 64'(4));
    take();

    // Reset mid-sum (with overflow set) and during OUTPUT
    repeat (3) accept(32'h4000_0000);
    check("pre_rst_ovf_b", 64'(ovf_b), 64'(1));
    check("pre_rst_term", 64'(term_a), 64'(3));
    pulse_reset("rst_mid");
    repeat (4) accept(32'd9);
    check("pre_rst_out_valid", 64'(valid_a), 64'(1));
    pulse_reset("rst_out");

    // NTERMS = 1: every accepted product yields a result
    c_valid = 1'b1;
    {prod_h, prod_l} = 32'hFFFF_FFF9;
    #1;
    check("c_ready", 64'(ready_c), 64'(1));
    @(posedge clk); #1;
    c_valid = 1'b0;
    check("c_valid", 64'(valid_c), 64'(1));
    check("c_acc", 64'(acc_c), 64'(40'hFF_FFFF_FFF9));
    check("c_term", 64'(term_c), 64'(1));
    check("c_ready_out", 64'(ready_c), 64'(0));
    c_ready = 1'b1;
    @(posedge clk); #1;
    c_ready = 1'b0;
    c_valid = 1'b1;
    {prod_h, prod_l} = 32'd9;
    @(posedge clk); #1;
    c_valid = 1'b0;
    check("c2_valid", 64'(valid_c), 64'(1));
    check("c2_acc", 64'(acc_c), 64'(9));
    check("c2_ovf", 64'(ovf_c), 64'(0));

    check("sb_drained", 64'(qa.size() + qb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
